// File: rtl/div_sqrt_iter_ctrl_pkg.sv
// Shared constants and types for the radix-2 div/sqrt sequencer.
// C_ITER_MAX is the number of quotient bits produced at full precision.
package fpu_defs_div_sqrt_tp;

  localparam int C_MANT       = 52;
  localparam int C_ITER_MAX   = C_MANT + 2;
  localparam int C_ITER_CNT_W = $clog2(C_ITER_MAX + 1);
  localparam int C_PREC_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } div_sqrt_state_e;

  // Requested bits minus one; zero or out-of-range means full precision.
  function automatic logic [C_ITER_CNT_W-1:0] calc_steps(
    input logic [C_PREC_W-1:0] prec
  );
    if (prec == '0 || int'(prec) >= C_MANT + 1)
      return C_ITER_CNT_W'(C_ITER_MAX);
    return C_ITER_CNT_W'(prec) + 1'b1;
  endfunction

endpackage

// File: rtl/div_sqrt_iter_ctrl_if.sv
// Request/result handshake between preprocessing and the sequencer.
// master: preprocessing side; slave: div_sqrt_iter_ctrl.
interface div_sqrt_iter_ctrl_if;
  import fpu_defs_div_sqrt_tp::*;

  logic                  Div_start_SI;
  logic                  Sqrt_start_SI;
  logic                  Kill_SI;
  logic [C_PREC_W-1:0]   Precision_ctl_SI;
  logic [C_ITER_MAX-1:0] Operand_a_DI;
  logic [C_ITER_MAX-1:0] Operand_b_DI;
  logic                  Ready_SO;
  logic                  Done_SO;
  logic [C_ITER_MAX-1:0] Quotient_DO;
  logic                  Rem_nonzero_SO;

  modport master (
    output Div_start_SI, Sqrt_start_SI, Kill_SI,
    output Precision_ctl_SI, Operand_a_DI, Operand_b_DI,
    input  Ready_SO, Done_SO, Quotient_DO, Rem_nonzero_SO
  );

  modport slave (
    input  Div_start_SI, Sqrt_start_SI, Kill_SI,
    input  Precision_ctl_SI, Operand_a_DI, Operand_b_DI,
    output Ready_SO, Done_SO, Quotient_DO, Rem_nonzero_SO
  );

endinterface

// File: rtl/div_sqrt_iter_ctrl.sv
// Radix-2 div/sqrt sequencer: FSM, step counter, left-align shifter.
// Optional early termination: DIV_SQRT_ITER_EARLY_TERM_EN.
module div_sqrt_iter_ctrl
  import fpu_defs_div_sqrt_tp::*;
(
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  div_sqrt_iter_ctrl_if.slave   bus,
  output logic [C_ITER_MAX-1:0] Iter_a_DO,
  output logic [C_ITER_MAX-1:0] Iter_b_DO,
  output logic                  Iter_div_enable_SO,
  output logic                  Iter_sqrt_enable_SO,
  output logic                  Iter_div_start_dly_SO,
  output logic [1:0]            Iter_d_DO,
  input  logic [C_ITER_MAX-1:0] Iter_sum_DI,
  input  logic                  Iter_carry_out_DI,
  input  logic [1:0]            Iter_d_DI
);

  localparam int W = C_ITER_MAX;
  localparam int CW = C_ITER_CNT_W;

  div_sqrt_state_e state_q, state_d;
  logic          sqrt_q, sqrt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [1:0]    dreg_q, dreg_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          rnz_q, rnz_d;

  logic          accept;
  logic          last;
  logic          early;
  logic          fin;
  logic [CW-1:0] taken;
  logic [W-1:0]  aligned;

  // Handshake qualifiers and the left-aligned result.
  always_comb begin
    accept = (state_q == IDLE) && !bus.Kill_SI &&
             (bus.Div_start_SI || bus.Sqrt_start_SI);
    last   = (cnt_q == CW'(1));
`ifdef DIV_SQRT_ITER_EARLY_TERM_EN
    early  = (Iter_sum_DI == '0) && Iter_carry_out_DI;
`else
    early  = 1'b0;
`endif
    fin     = (state_q == DONE) && !bus.Kill_SI;
    taken   = steps_q - cnt_q;
    aligned = quot_q << (CW'(W) - taken);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    sqrt_d  = sqrt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    dreg_d  = dreg_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rnz_d   = rnz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ITER;
          sqrt_d  = !bus.Div_start_SI;
          rem_d   = bus.Operand_a_DI;
          dvs_d   = bus.Operand_b_DI;
          quot_d  = '0;
          dreg_d  = '0;
          steps_d = calc_steps(bus.Precision_ctl_SI);
          cnt_d   = steps_d;
        end
      end
      ITER: begin
        rem_d  = {Iter_sum_DI[W-2:0], 1'b0};
        quot_d = {quot_q[W-2:0], Iter_carry_out_DI};
        cnt_d  = cnt_q - 1'b1;
        if (sqrt_q)
          dreg_d = Iter_d_DI;
        if (last || early)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (fin) begin
          res_d = aligned;
          rnz_d = |rem_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.Kill_SI)
      state_d = IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      sqrt_q  <= 1'b0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      dreg_q  <= '0;
      steps_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rnz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sqrt_q  <= sqrt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      dreg_q  <= dreg_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rnz_q   <= rnz_d;
    end
  end

  // Outputs decoded from registered state only (plus kill masking).
  always_comb begin
    bus.Ready_SO          = (state_q == IDLE);
    bus.Done_SO           = fin;
    bus.Quotient_DO       = fin ? aligned : res_q;
    bus.Rem_nonzero_SO    = fin ? |rem_q : rnz_q;
    Iter_a_DO             = '0;
    Iter_b_DO             = '0;
    Iter_div_enable_SO    = 1'b0;
    Iter_sqrt_enable_SO   = 1'b0;
    Iter_div_start_dly_SO = 1'b0;
    Iter_d_DO             = '0;
    if (state_q == ITER) begin
      Iter_a_DO             = rem_q;
      Iter_b_DO             = sqrt_q ? '0 : dvs_q;
      Iter_div_enable_SO    = !sqrt_q;
      Iter_sqrt_enable_SO   = sqrt_q;
      Iter_div_start_dly_SO = !sqrt_q && (cnt_q == steps_q);
      Iter_d_DO             = dreg_q;
    end
  end

endmodule

// File: tb/tb_div_sqrt_iter_ctrl.sv
// Directed bench for div_sqrt_iter_ctrl with a scripted iteration unit.
// Early-termination expectations follow DIV_SQRT_ITER_EARLY_TERM_EN.
module tb_div_sqrt_iter_ctrl;
  import fpu_defs_div_sqrt_tp::*;

  localparam int W = C_ITER_MAX;
  localparam logic [W-1:0] Q_SQRT = {{24{1'b1}}, {30{1'b0}}};
  localparam logic [W-1:0] Q_SIM  = {{8{1'b1}}, {46{1'b0}}};
`ifdef DIV_SQRT_ITER_EARLY_TERM_EN
  localparam int           ET_DONE = 6;
  localparam logic [W-1:0] ET_Q    = {{5{1'b1}}, {49{1'b0}}};
  localparam logic         ET_RNZ  = 1'b0;
`else
  localparam int           ET_DONE = 55;
  localparam logic [W-1:0] ET_Q    = {W{1'b1}};
  localparam logic         ET_RNZ  = 1'b1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] it_a, it_b, it_sum;
  logic         it_den, it_sen, it_dly, it_co;
  logic [1:0]   it_do, it_di;

  int n_chk = 0;
  int n_fail = 0;

  div_sqrt_iter_ctrl_if bus ();

  div_sqrt_iter_ctrl dut (
    .Clk_CI               (clk),
    .Rst_RI               (rst),
    .bus                  (bus),
    .Iter_a_DO            (it_a),
    .Iter_b_DO            (it_b),
    .Iter_div_enable_SO   (it_den),
    .Iter_sqrt_enable_SO  (it_sen),
    .Iter_div_start_dly_SO(it_dly),
    .Iter_d_DO            (it_do),
    .Iter_sum_DI          (it_sum),
    .Iter_carry_out_DI    (it_co),
    .Iter_d_DI            (it_di)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic dv, input logic sq,
                          input logic [5:0] prec,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
    bus.Div_start_SI     = dv;
    bus.Sqrt_start_SI    = sq;
    bus.Precision_ctl_SI = prec;
    bus.Operand_a_DI     = a;
    bus.Operand_b_DI     = b;
    tick();
    bus.Div_start_SI  = 1'b0;
    bus.Sqrt_start_SI = 1'b0;
  endtask

  int           en_cnt, dly_cnt, done_cyc, rdy_cyc, done_n, d_bad, b_bad;
  logic [W-1:0] q_obs, q_exp;
  logic         r_obs;

  initial begin
    rst = 1'b1;
    bus.Div_start_SI = 1'b0;
    bus.Sqrt_start_SI = 1'b0;
    bus.Kill_SI = 1'b0;
    bus.Precision_ctl_SI = '0;
    bus.Operand_a_DI = '0;
    bus.Operand_b_DI = '0;
    it_sum = '0;
    it_co = 1'b0;
    it_di = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 64'(bus.Ready_SO), 64'd1);
    chk("rst_done", 64'(bus.Done_SO), 64'd0);
    chk("rst_quot", 64'(bus.Quotient_DO), 64'd0);
    chk("rst_rnz", 64'(bus.Rem_nonzero_SO), 64'd0);
    chk("rst_en", 64'({it_den, it_sen, it_dly}), 64'd0);

    // Full-precision division, carry alternating 1,0,1,...
    it_sum = W'(1);
    start_op(1'b1, 1'b0, 6'd0, W'(54'h123), W'(54'h456));
    chk("div_a1", 64'(it_a), 64'h123);
    chk("div_b1", 64'(it_b), 64'h456);
    en_cnt = 0; dly_cnt = 0; done_cyc = 0; rdy_cyc = 0;
    q_exp = '0; q_obs = '0; r_obs = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.Done_SO && done_cyc == 0) begin
        done_cyc = k;
        q_obs = bus.Quotient_DO;
        r_obs = bus.Rem_nonzero_SO;
      end
      if (bus.Ready_SO && rdy_cyc == 0) rdy_cyc = k;
      en_cnt += int'(it_den);
      dly_cnt += int'(it_dly);
      it_co = k[0];
      if (k <= W) q_exp = {q_exp[W-2:0], k[0]};
      tick();
    end
    chk("div_en_cycles", 64'(en_cnt), 64'd54);
    chk("div_dly_cycles", 64'(dly_cnt), 64'd1);
    chk("div_done_cycle", 64'(done_cyc), 64'd55);
    chk("div_ready_cycle", 64'(rdy_cyc), 64'd56);
    chk("div_quot", 64'(q_obs), 64'(q_exp));
    chk("div_rnz", 64'(r_obs), 64'd1);

    // Reduced-precision sqrt, carry forced high.
    it_co = 1'b1;
    it_di = 2'd0;
    start_op(1'b0, 1'b1, 6'd23, W'(54'hABC), W'(54'h777));
    chk("sqrt_a1", 64'(it_a), 64'hABC);
    chk("sqrt_d1", 64'(it_do), 64'd0);
    en_cnt = 0; dly_cnt = 0; done_cyc = 0; rdy_cyc = 0;
    d_bad = 0; b_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.Done_SO && done_cyc == 0) begin
        done_cyc = k;
        q_obs = bus.Quotient_DO;
      end
      if (bus.Ready_SO && rdy_cyc == 0) rdy_cyc = k;
      en_cnt += int'(it_sen);
      dly_cnt += int'(it_den);
      if (it_sen && it_b != '0) b_bad++;
      if (k >= 2 && it_sen && it_do != 2'(k - 1)) d_bad++;
      it_di = 2'(k);
      tick();
    end
    chk("sqrt_en_cycles", 64'(en_cnt), 64'd24);
    chk("sqrt_div_en", 64'(dly_cnt), 64'd0);
    chk("sqrt_b_zero", 64'(b_bad), 64'd0);
    chk("sqrt_d_follow", 64'(d_bad), 64'd0);
    chk("sqrt_done_cycle", 64'(done_cyc), 64'd25);
    chk("sqrt_ready_cycle", 64'(rdy_cyc), 64'd26);
    chk("sqrt_quot", 64'(q_obs), 64'(Q_SQRT));

    // Kill in ITER cycle 10.
    start_op(1'b1, 1'b0, 6'd0, W'(54'h5), W'(54'h9));
    for (int k = 1; k <= 9; k++) tick();
    bus.Kill_SI = 1'b1;
    tick();
    bus.Kill_SI = 1'b0;
    chk("kill_ready", 64'(bus.Ready_SO), 64'd1);
    chk("kill_quot", 64'(bus.Quotient_DO), 64'(Q_SQRT));
    chk("kill_rnz", 64'(bus.Rem_nonzero_SO), 64'd1);
    done_n = 0;
    for (int k = 0; k < 60; k++) begin
      done_n += int'(bus.Done_SO);
      tick();
    end
    chk("kill_no_done", 64'(done_n), 64'd0);

    // Simultaneous starts; late div start in cycle 3 ignored.
    start_op(1'b1, 1'b1, 6'd7, W'(54'h11), W'(54'h22));
    chk("sim_div_en", 64'(it_den), 64'd1);
    chk("sim_sqrt_en", 64'(it_sen), 64'd0);
    done_n = 0; done_cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.Done_SO) begin
        done_n++;
        if (done_cyc == 0) begin
          done_cyc = k;
          q_obs = bus.Quotient_DO;
        end
      end
      bus.Div_start_SI = (k == 3);
      tick();
    end
    bus.Div_start_SI = 1'b0;
    chk("sim_done_count", 64'(done_n), 64'd1);
    chk("sim_done_cycle", 64'(done_cyc), 64'd9);
    chk("sim_quot", 64'(q_obs), 64'(Q_SIM));

    // Zero sum with carry at step 5.
    it_co = 1'b1;
    it_sum = W'(5);
    start_op(1'b1, 1'b0, 6'd0, W'(54'h3), W'(54'h1));
    done_cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.Done_SO && done_cyc == 0) begin
        done_cyc = k;
        q_obs = bus.Quotient_DO;
        r_obs = bus.Rem_nonzero_SO;
      end
      it_sum = (k == 5) ? '0 : W'(5);
      tick();
    end
    chk("et_done_cycle", 64'(done_cyc), 64'(ET_DONE));
    chk("et_quot", 64'(q_obs), 64'(ET_Q));
    chk("et_rnz", 64'(r_obs), 64'(ET_RNZ));

    // Reset held two cycles mid-ITER.
    start_op(1'b1, 1'b0, 6'd0, W'(54'h7), W'(54'h3));
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("mrst_ready", 64'(bus.Ready_SO), 64'd1);
    chk("mrst_done", 64'(bus.Done_SO), 64'd0);
    chk("mrst_quot", 64'(bus.Quotient_DO), 64'd0);
    chk("mrst_en", 64'({it_den, it_sen, it_dly}), 64'd0);
    chk("mrst_a", 64'(it_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sqrt_iter_ctrl.md
# div_sqrt_iter_ctrl

Sequencer for the radix-2 div/sqrt iteration datapath. The block accepts a divide or square-root request through a start/ready handshake and holds the partial remainder, divisor and quotient registers. It drives the iteration unit's operands and control inputs once per cycle for a precision-dependent number of steps, then returns a left-aligned quotient and a remainder-nonzero sticky bit. It sits between the div/sqrt preprocessing stage and the normalisation/rounding stage; the iteration unit is instantiated by the parent.

## Interface
- C_PREC_W, 6, width of the precision control input
- Clk_CI  in  1  clock
- Rst_RI  in  1  reset; **synchronous, active-high**
- Div_start_SI  in  1  request division
- Sqrt_start_SI  in  1  request square root
- Kill_SI  in  1  abort the current operation
- Precision_ctl_SI  in  C_PREC_W  requested quotient bits minus 1; 0 means full precision
- Operand_a_DI  in  C_MANT+2  dividend/radicand mantissa, sampled at accept
- Operand_b_DI  in  C_MANT+2  divisor mantissa, sampled at accept
- Ready_SO  out  1  able to accept a start
- Done_SO  out  1  one-cycle result-valid pulse
- Quotient_DO  out  C_MANT+2  left-aligned result; held until the next accept
- Rem_nonzero_SO  out  1  final partial remainder is nonzero
- Iter_a_DO / Iter_b_DO  out  C_MANT+2  iteration operands
- Iter_div_enable_SO, Iter_sqrt_enable_SO, Iter_div_start_dly_SO  out  1  iteration controls
- Iter_d_DO  out  2  sqrt digit state to the iteration unit
- Iter_sum_DI  in  C_MANT+2  iteration sum
- Iter_carry_out_DI  in  1  iteration carry-out, which is the quotient bit
- Iter_d_DI  in  2  next digit state from the iteration unit

## Operation
- **States:** IDLE, ITER, DONE.
- **IDLE:**
  - Ready_SO=1.
  - Div_start_SI or Sqrt_start_SI high → accept and go to ITER.
  - Both high → division wins.
  - On accept: latch the operands and the mode, clear the quotient register, clear the D register, and load Steps.
- **Steps:** equals C_MANT+2 when Precision_ctl_SI is 0 or is ≥ C_MANT+1; otherwise Precision_ctl_SI+1.
- **ITER, one step per cycle:**
  - Iter_a_DO = partial remainder register.
  - Iter_b_DO = divisor register in division, 0 in sqrt.
  - Iter_div_enable_SO or Iter_sqrt_enable_SO = 1 according to mode.
  - Iter_div_start_dly_SO = 1 only in the first ITER cycle of a division.
  - Iter_d_DO = D register. In sqrt mode the D register takes Iter_d_DI each step; in division it stays 0.
  - At each edge: remainder ← Iter_sum_DI shifted left by 1; quotient ← {quotient, Iter_carry_out_DI}; step counter decrements.
  - After the last step → DONE.
- **DONE:**
  - Done_SO=1.
  - Quotient_DO = quotient register shifted left by (C_MANT+2−Steps).
  - Rem_nonzero_SO = OR-reduction of the final remainder.
  - Next state IDLE.
- Starts during ITER or DONE are ignored; there is no queueing.
- **Kill_SI** in any state → IDLE at the next edge. No Done_SO is produced, and Quotient_DO and Rem_nonzero_SO keep their previous values. Kill wins over a simultaneous start.
- **Reset** at any time forces IDLE.

## Timing
- **Reset values:** state IDLE, Ready_SO=1, Done_SO=0, Quotient_DO=0, Rem_nonzero_SO=0, all Iter_* outputs 0.
- **Accept edge E0:** ITER occupies cycles 1..Steps and DONE occupies cycle Steps+1.
  - Done_SO is high in cycle Steps+1.
  - Ready_SO is high again in cycle Steps+2.
- **Full precision (C_MANT=52):** 54 ITER cycles, Done_SO in cycle 55.
- **Iter_* outputs:** decoded from registered state only. The iteration path is combinational, from these outputs to Iter_sum_DI and back to a register.

## Configuration
- **DIV_SQRT_ITER_EARLY_TERM_EN**
  - **Defined:** in ITER, if Iter_sum_DI==0 and Iter_carry_out_DI==1, that step is the last one. The FSM enters DONE at the next edge, and the unfilled low quotient bits are zero (same left-align rule, using the number of steps actually taken). Rem_nonzero_SO=0.
  - **Undefined:** Steps are always completed.

## Structure
- **Shared package fpu_defs_div_sqrt_tp:**
  - C_MANT.
  - C_ITER_MAX = C_MANT+2.
  - C_ITER_CNT_W = $clog2(C_ITER_MAX+1).
  - State enum typedef (IDLE/ITER/DONE).
- **No sub-module.** FSM, step counter and left-align shifter live in this block; the iteration datapath is external.

## Test plan
- **Reset:** hold Rst_RI high 2 cycles mid-ITER → cycle after: Ready_SO=1, Done_SO=0, Quotient_DO=0, all enables 0.
- **Full-precision division:** Div_start_SI with Precision_ctl_SI=0 → Iter_div_enable_SO high 54 cycles, Iter_div_start_dly_SO high only in cycle 1, Done_SO high in cycle 55, Ready_SO high in cycle 56.
- **Reduced-precision sqrt:** Sqrt_start_SI, Precision_ctl_SI=23, model forcing carry=1 → 24 ITER cycles, Quotient_DO = 24 ones then 30 zeros, Iter_d_DO = previous cycle's Iter_d_DI.
- **Kill:** Kill_SI in ITER cycle 10 → IDLE next edge, no Done_SO, Quotient_DO unchanged from the prior result.
- **Simultaneous starts:** Div and Sqrt starts together → division runs. Div_start_SI asserted in ITER cycle 3 → ignored, Done_SO count stays 1.
- **Early termination (macro defined):** Iter_sum_DI=0 with carry=1 at step 5 → Done_SO in cycle 6, Quotient_DO low 49 bits 0, Rem_nonzero_SO=0. Without the macro → all 54 steps complete.
